// File: rtl/stoch_decoder.sv
// ---------------------------------------------------------------------------
// stoch_decoder
//
// Decodes a signed stochastic bitstream carried on two channels (in_p/in_m)
// into a two's-complement count. Every 2^WINDOW_LOG2 enabled bit pairs form
// one window. Each pair contributes +1 for (1,0), -1 for (0,1) and 0
// otherwise. The window total is presented through a valid/ready output
// register. Accumulation never stalls: if a new window completes while the
// previous result is still unconsumed, the old result is overwritten and a
// sticky overrun flag is raised.
//
// Parameters
//   WINDOW_LOG2 : log2 of the window length N
//   OUT_WIDTH   : signed result width, must be at least WINDOW_LOG2+2
//
// Ports
//   CLK        in   rising-edge clock
//   RST        in   asynchronous active-high reset
//   clr        in   synchronous flush of window state and overrun flag
//   en         in   in_p/in_m carry a valid bit pair this cycle
//   in_p       in   positive stochastic channel
//   in_m       in   negative stochastic channel
//   out_ready  in   consumer accepts out_value this cycle
//   out_valid  out  out_value holds an unconsumed window result
//   out_value  out  signed window sum (OUT_WIDTH bits)
//   overrun    out  sticky: a result was overwritten before acceptance
// ---------------------------------------------------------------------------
module stoch_decoder #(
  parameter int WINDOW_LOG2 = 8,
  parameter int OUT_WIDTH   = WINDOW_LOG2 + 2
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        clr,
  input  logic                        en,
  input  logic                        in_p,
  input  logic                        in_m,
  input  logic                        out_ready,
  output logic                        out_valid,
  output logic signed [OUT_WIDTH-1:0] out_value,
  output logic                        overrun
);

  // Accumulator width covers [-N, +N] without overflow.
  localparam int ACC_W = WINDOW_LOG2 + 2;

  localparam logic [0:0] ACCUM = 1'b0;  // window in progress, nothing pending
  localparam logic [0:0] HOLD  = 1'b1;  // result pending for the consumer

  if (OUT_WIDTH < ACC_W) begin : g_bad_width
    $error("stoch_decoder: OUT_WIDTH must be at least WINDOW_LOG2+2");
  end

  logic [0:0]              state;
  logic [0:0]              state_next;
  logic [WINDOW_LOG2-1:0]  bit_cnt;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] contrib;
  logic signed [ACC_W-1:0] window_sum;
  logic                    complete;

  // Per-bit contribution; disabled cycles and (1,1)/(0,0) contribute zero.
  always_comb begin
    contrib = '0;
    if (en && in_p && !in_m) begin
      contrib = {{(ACC_W-1){1'b0}}, 1'b1};
    end else if (en && !in_p && in_m) begin
      contrib = '1;
    end
  end

  // Including the current bit lets the completing cycle produce the full
  // window total while the accumulator restarts with no gap.
  assign window_sum = acc + contrib;
  assign complete   = en && (&bit_cnt);

  always_comb begin
    state_next = state;
    case (state)
      ACCUM: if (complete) state_next = HOLD;
      HOLD: begin
        if (complete) begin
          state_next = HOLD;
        end else if (out_ready) begin
          state_next = ACCUM;
        end
      end
      default: state_next = ACCUM;
    endcase
  end

  assign out_valid = (state == HOLD);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= ACCUM;
      bit_cnt   <= '0;
      acc       <= '0;
      out_value <= '0;
      overrun   <= 1'b0;
    end else if (clr) begin
      // Flush wins over en and completion; out_value is left untouched.
      state   <= ACCUM;
      bit_cnt <= '0;
      acc     <= '0;
      overrun <= 1'b0;
    end else begin
      state <= state_next;
      if (en) begin
        bit_cnt <= bit_cnt + 1'b1;
        acc     <= complete ? '0 : window_sum;
      end
      if (complete) begin
        out_value <= OUT_WIDTH'(window_sum);
        // Overwriting a pending result the consumer is not taking now.
        if (state == HOLD && !out_ready) begin
          overrun <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_stoch_decoder.sv
// ---------------------------------------------------------------------------
// tb_stoch_decoder
//
// Self-checking bench for stoch_decoder with WINDOW_LOG2=4 (N=16).
// The stimulus side keeps a window-level reference (bits seen, running sum,
// pending result, sticky overrun) and pushes each expected window result
// into a queue. A monitor on the falling edge pops and checks a result
// whenever the DUT hands one over (out_valid & out_ready), checks that a
// pending result is held stable, and checks all-zero outputs during reset.
// ---------------------------------------------------------------------------
module tb_stoch_decoder;

  localparam int WL2 = 4;
  localparam int N   = 1 << WL2;
  localparam int OW  = WL2 + 2;

  logic                 CLK;
  logic                 RST;
  logic                 clr;
  logic                 en;
  logic                 in_p;
  logic                 in_m;
  logic                 out_ready;
  logic                 out_valid;
  logic signed [OW-1:0] out_value;
  logic                 overrun;

  stoch_decoder #(.WINDOW_LOG2(WL2), .OUT_WIDTH(OW)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .clr       (clr),
    .en        (en),
    .in_p      (in_p),
    .in_m      (in_m),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_value (out_value),
    .overrun   (overrun)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    int value;
    bit ovr;
    int vis;   // first cycle the result should be visible
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  // Window-level reference state.
  int wcnt    = 0;
  int wsum    = 0;
  bit pending = 1'b0;
  bit ovr_m   = 1'b0;

  always @(posedge CLK) cyc <= cyc + 1;

  function automatic void chk(string name, bit ok, int act, int req);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s at cycle %0d: actual=%0d required=%0d", name, cyc, act, req);
    end
  endfunction

  // Applies one cycle of inputs (sampled at the next rising edge) and
  // advances the reference to the state after that edge.
  task automatic drive(input bit c, input bit e, input bit p, input bit m, input bit r);
    int   contrib;
    exp_t ent;
    @(posedge CLK);
    #1;
    clr = c; en = e; in_p = p; in_m = m; out_ready = r;
    contrib = 0;
    if (e && p && !m) contrib = 1;
    if (e && !p && m) contrib = -1;
    if (pending && r) pending = 1'b0;      // monitor takes it this cycle
    if (c) begin
      if (pending && exp_q.size() > 0) void'(exp_q.pop_back());
      pending = 1'b0;
      ovr_m   = 1'b0;
      wcnt    = 0;
      wsum    = 0;
    end else if (e) begin
      wsum += contrib;
      wcnt++;
      if (wcnt == N) begin
        if (pending) begin
          if (exp_q.size() > 0) void'(exp_q.pop_back());
          ovr_m = 1'b1;
        end
        ent.value = wsum;
        ent.ovr   = ovr_m;
        ent.vis   = cyc + 1;
        exp_q.push_back(ent);
        pending = 1'b1;
        wcnt    = 0;
        wsum    = 0;
      end
    end
  endtask

  task automatic idle(input int n, input bit r);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, r);
  endtask

  task automatic do_reset();
    @(posedge CLK);
    #1;
    RST = 1'b1; clr = 1'b0; en = 1'b0; in_p = 1'b0; in_m = 1'b0;
    exp_q.delete();
    wcnt = 0; wsum = 0; pending = 1'b0; ovr_m = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  // Monitor: decoupled from the stimulus, driven only by the DUT outputs.
  always @(negedge CLK) begin
    exp_t e;
    if (RST) begin
      chk("reset_valid",   out_valid == 1'b0, int'(out_valid), 0);
      chk("reset_value",   out_value == '0,   int'(out_value), 0);
      chk("reset_overrun", overrun == 1'b0,   int'(overrun),   0);
    end else if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 1'b0, int'(out_value), 0);
      end else begin
        e = exp_q.pop_front();
        chk("result_value",   int'(out_value) == e.value, int'(out_value), e.value);
        chk("result_overrun", overrun == e.ovr, int'(overrun), int'(e.ovr));
        chk("result_early",   e.vis <= cyc, cyc, e.vis);
      end
    end else if (exp_q.size() > 0 && exp_q[0].vis <= cyc) begin
      if (!out_valid) begin
        chk("result_missing", 1'b0, 0, 1);
        void'(exp_q.pop_front());
      end else begin
        chk("hold_stable", int'(out_value) == exp_q[0].value, int'(out_value), exp_q[0].value);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    RST = 1'b1; clr = 1'b0; en = 1'b0; in_p = 1'b0; in_m = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b0;

    // Full positive window, consumer always ready.
    for (int k = 0; k < N; k++) drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    idle(3, 1'b1);

    // Alternating +1/-1 with random disabled gaps carrying junk data.
    for (int k = 0; k < N; k++) begin
      drive(1'b0, 1'b1, (k % 2) == 0, (k % 2) == 1, 1'b1);
      for (int g = 0; g < int'($urandom_range(0, 3)); g++)
        drive(1'b0, 1'b0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 1'b1);
    end
    idle(3, 1'b1);

    // -16 held unconsumed, then overwritten by a (1,1) window -> 0, overrun.
    for (int k = 0; k < N; k++) drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(4, 1'b0);
    for (int k = 0; k < N; k++) drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(3, 1'b0);
    idle(2, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

    // Pending +16 accepted on the same cycle the +12 window completes.
    for (int k = 0; k < N; k++) drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < N; k++)
      drive(1'b0, 1'b1, k < 12, 1'b0, k == N - 1);
    idle(3, 1'b1);

    // Reset in the middle of a window discards the partial sum.
    for (int k = 0; k < 7; k++) drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    do_reset();
    for (int k = 0; k < N; k++) drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    idle(3, 1'b1);

    // clr on the completing bit: no result, next window independent.
    for (int k = 0; k < N - 1; k++) drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    for (int k = 0; k < N; k++)
      drive(1'b0, 1'b1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 1'b1);
    idle(3, 1'b1);

    // Random traffic with sporadic back-pressure, flushes and resets.
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 79) == 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
            $urandom_range(0, 3) != 0);
      if ($urandom_range(0, 249) == 0) do_reset();
    end

    idle(4, 1'b1);
    chk("drain_empty", exp_q.size() == 0, exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stoch_decoder.md
STOCH_DECODER -- requirements
Module: stoch_decoder

Interface
REQ-001 SHALL have parameter WINDOW_LOG2, default 8, log2 of the number of valid bits per decode window (N = 2^WINDOW_LOG2).
REQ-002 SHALL have parameter OUT_WIDTH, default WINDOW_LOG2+2, signed result width; values below WINDOW_LOG2+2 are illegal.
REQ-003 SHALL have port CLK  input  1  rising-edge clock, the only clock.
REQ-004 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port clr  input  1  synchronous flush of window state and overrun flag.
REQ-006 SHALL have port en  input  1  qualifies in_p/in_m as one stochastic bit pair this cycle.
REQ-007 SHALL have port in_p  input  1  positive channel of the signed stochastic bitstream.
REQ-008 SHALL have port in_m  input  1  negative channel of the signed stochastic bitstream.
REQ-009 SHALL have port out_ready  input  1  consumer accepts out_value this cycle.
REQ-010 SHALL have port out_valid  output  1  out_value holds an unconsumed window result.
REQ-011 SHALL have port out_value  output  OUT_WIDTH  signed sum of window contributions, two's complement.
REQ-012 SHALL have port overrun  output  1  sticky: a completed result was overwritten before acceptance.

Function
REQ-013 SHALL assign each enabled cycle a contribution: +1 if in_p=1,in_m=0; -1 if in_p=0,in_m=1; 0 otherwise.
REQ-014 SHALL ignore in_p/in_m on cycles with en=0; neither accumulator nor bit counter changes.
REQ-015 SHALL keep a WINDOW_LOG2-bit bit counter incrementing by 1 per enabled cycle, wrapping N-1 -> 0.
REQ-016 SHALL keep a signed accumulator of width WINDOW_LOG2+2; range [-N, +N] never overflows.
REQ-017 SHALL complete a window on the enabled cycle where the bit counter equals N-1.
REQ-018 On completion, SHALL register out_value = accumulator + current contribution (sign-extended to OUT_WIDTH), set out_valid=1 next cycle, and clear accumulator to 0 so the next enabled bit starts a new window with no gap.
REQ-019 Latency: out_valid SHALL rise exactly one cycle after the completing enabled bit.
REQ-020 SHALL implement two states: ACCUM (window in progress, result not pending) and HOLD (result pending); accumulation continues in both.
REQ-021 ACCUM -> HOLD on completion; HOLD -> ACCUM on out_valid&out_ready without simultaneous completion; HOLD stays HOLD otherwise.
REQ-022 out_valid and out_value SHALL remain stable in HOLD until out_ready=1.
REQ-023 Completion in HOLD with out_ready=0 SHALL overwrite out_value, keep out_valid=1, and set overrun=1.
REQ-024 Completion in HOLD with out_ready=1 same cycle SHALL load the new value, keep out_valid=1, and not set overrun.
REQ-025 overrun SHALL stay 1 until clr or RST.
REQ-026 clr=1 SHALL next cycle zero accumulator, bit counter, out_valid, overrun and return to ACCUM; clr has priority over en and completion in the same cycle; out_value keeps its last value.

Reset
REQ-027 RST=1 SHALL immediately force state ACCUM, accumulator=0, bit counter=0, out_valid=0, out_value=0, overrun=0, independent of CLK.
REQ-028 RST asserted mid-window SHALL discard the partial window; the first enabled bit after RST release is bit 0 of a fresh window.

Verification (WINDOW_LOG2=4, N=16)
REQ-029 16 enabled cycles in_p=1,in_m=0, out_ready=1 -> out_valid pulses one cycle after 16th bit, out_value=+16.
REQ-030 16 enabled cycles alternating (1,0),(0,1), with en=0 gaps of random length in between -> out_value=0, gaps do not shift completion.
REQ-031 Window of 16 x (0,1), out_ready=0, then 16 x (1,1) -> first out_value=-16 held stable, second completion gives out_value=0, overrun=1.
REQ-032 Result pending, out_ready=1 on the same cycle as next completion (window of 12x(1,0),4x(0,0)) -> out_value=+12, out_valid stays 1, overrun=0.
REQ-033 RST pulsed after 7 enabled bits of (1,0), then 16 x (0,1) -> all outputs 0 during reset, next result -16.
REQ-034 clr asserted on the completing cycle -> no out_valid, accumulator and counter 0, next window decodes independently.
